npu_fmap_router: RTL

Parametrised feature-map collector between NUM_ENG convolution engines and the fully-connected stage. It latches an engine-select mode on start, launches the selected engine, and captures that engine's LANES-wide output beats into LANES banked RAMs. When the engine signals end-of-layer, it hands the buffer to the FC stage, which reads one byte per request by bank and address. It replaces the fixed two-structure mode mux and per-structure output buffer with one generic, N-way, mode-latched block.

---
 rtl/npu_pkg.sv | 22 ++
 rtl/fmap_bank.sv | 30 +++
 rtl/npu_fmap_router.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// Shared types and defaults for the feature-map router.
// The state enum, the default geometry and the width helper live here.
package npu_pkg;

  localparam int DEF_NUM_ENG = 2;
  localparam int DEF_LANES   = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_DEPTH   = 2048;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_FILL,
    ST_READY
  } fmap_state_e;

  // Index width for a field of `value` entries; it never drops below one bit.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/fmap_bank.sv
// One lane bank of the feature-map buffer: DEPTH x DATA_W simple dual-port RAM.
// It has a synchronous write port and a registered synchronous read port.
module fmap_bank #(
  parameter int DEPTH  = 2048,
  parameter int DATA_W = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array is never reset so it can map onto block RAM; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/npu_fmap_router.sv
// N-way mode-latched feature-map collector between the conv engines and the FC stage.
// Define NPU_FMAP_RDREG_EN to add an output register after the bank mux (2-cycle reads).
module npu_fmap_router
  import npu_pkg::*;
#(
  parameter  int NUM_ENG = DEF_NUM_ENG,
  parameter  int LANES   = DEF_LANES,
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int DEPTH   = DEF_DEPTH,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int SEL_W   = clog2_min1(NUM_ENG),
  localparam int BANK_W  = clog2_min1(LANES)
) (
  input  logic                             clk,
  input  logic                             global_rst,
  input  logic [SEL_W-1:0]                 mode,
  input  logic                             start,
  output logic [NUM_ENG-1:0]               eng_start,
  input  logic [NUM_ENG-1:0]               wr_vld,
  input  logic [NUM_ENG*ADDR_W-1:0]        wr_addr,
  input  logic [NUM_ENG*LANES*DATA_W-1:0]  wr_data,
  input  logic [NUM_ENG-1:0]               eng_end,
  input  logic                             rd_en,
  input  logic [BANK_W-1:0]                rd_bank,
  input  logic [ADDR_W-1:0]                rd_addr,
  input  logic                             rd_done,
  output logic [DATA_W-1:0]                rd_data,
  output logic                             rd_vld,
  output logic                             fmap_ready,
  output logic                             busy,
  output logic                             err
);

  localparam logic [SEL_W:0]  ENG_CNT  = (SEL_W + 1)'(NUM_ENG);
  localparam logic [BANK_W:0] LANE_CNT = (BANK_W + 1)'(LANES);

  fmap_state_e state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic                    mode_ok;
  logic                    mode_err;
  logic [NUM_ENG-1:0]      sel_onehot;
  logic [ADDR_W-1:0]       fill_addr;
  logic [LANES*DATA_W-1:0] fill_beat;
  logic                    sel_wr;
  logic                    sel_end;
  logic                    foreign_wr;
  logic                    rd_acc;
  logic                    bank_ok;
  logic [BANK_W-1:0]       bank_q;
  logic                    vld_q;
  logic [DATA_W-1:0]       bank_rdata [LANES];
  logic [DATA_W-1:0]       mux_data;

  assign mode_ok = ({1'b0, mode} < ENG_CNT);
  assign bank_ok = ({1'b0, rd_bank} < LANE_CNT);
  assign busy    = (state_q != ST_IDLE);

  // Write-side engine select: route the latched engine's address and beat to the banks.
  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    sel_onehot = '0;
    fill_addr  = '0;
    fill_beat  = '0;
    for (int k = 0; k < NUM_ENG; k++) begin
      if (sel_q == SEL_W'(k)) begin
        sel_onehot[k] = 1'b1;
        fill_addr     = wr_addr[k*ADDR_W +: ADDR_W];
        fill_beat     = wr_data[k*LANES*DATA_W +: LANES*DATA_W];
      end
    end
  end

  assign sel_wr     = (state_q == ST_FILL) && |(wr_vld & sel_onehot);
  assign sel_end    = (state_q == ST_FILL) && |(eng_end & sel_onehot);
  assign foreign_wr = (state_q == ST_FILL) && |(wr_vld & ~sel_onehot);
  assign rd_acc     = (state_q == ST_READY) && rd_en;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    mode_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (mode_ok) begin
            state_d = ST_ARM;
            sel_d   = mode;
          end else begin
            mode_err = 1'b1;
          end
        end
      end
      ST_ARM:  state_d = ST_FILL;
      ST_FILL: if (sel_end) state_d = ST_READY;
      ST_READY: begin
        // A valid restart wins over rd_done; an invalid one is flagged like in IDLE.
        if (start && mode_ok) begin
          state_d = ST_ARM;
          sel_d   = mode;
        end else begin
          mode_err = start;
          if (rd_done) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every one samples pre-edge values.
  always_ff @(posedge clk) begin
    if (global_rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      eng_start  <= '0;
      fmap_ready <= 1'b0;
      err        <= 1'b0;
      vld_q      <= 1'b0;
      bank_q     <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      eng_start  <= (state_q == ST_ARM) ? sel_onehot : '0;
      fmap_ready <= sel_end;
      err        <= err | mode_err | foreign_wr | (rd_acc && !bank_ok);
      vld_q      <= rd_acc;
      if (rd_acc) bank_q <= rd_bank;
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_bank
    fmap_bank #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk     (clk),
      .rst     (global_rst),
      .wr_en   (sel_wr),
      .wr_addr (fill_addr),
      .wr_data (fill_beat[j*DATA_W +: DATA_W]),
      .rd_en   (rd_acc),
      .rd_addr (rd_addr),
      .rd_data (bank_rdata[j])
    );
  end

  // Bank mux; an out-of-range bank matches nothing and reads as zero.
  always_comb begin
    mux_data = '0;
    for (int j = 0; j < LANES; j++) begin
      if (bank_q == BANK_W'(j)) mux_data = bank_rdata[j];
    end
  end

`ifdef NPU_FMAP_RDREG_EN
  always_ff @(posedge clk) begin
    if (global_rst) begin
      rd_vld  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_vld <= vld_q;
      if (vld_q) rd_data <= mux_data;
    end
  end
`else
  assign rd_vld  = vld_q;
  assign rd_data = mux_data;
`endif

endmodule
